core_ex_arbiter: RTL and testbench
==================================

# core_ex_arbiter

Shares one `core_execution_stage` instance between NUM_REQ requesters, e.g. the main pipeline and the CSR/debug path. It arbitrates with a rotating (round-robin) priority. The granted operation drives the execution stage combinationally. The block registers the result in a single-entry response buffer that has a valid/ready handshake and carries the winner's ID.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (≥2)
- ID_WIDTH, $clog2(NUM_REQ), width of response ID

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  operation pending per requester
- req_ready  out  NUM_REQ  operation accepted this cycle (one-hot or zero)
- req_op  in  NUM_REQ × ex_req_t  per-requester operation {alu_op, shift_op, alu_control, shift_control, a, b}
- ex_alu_op, ex_shift_op  out  1 each  to execution stage
- ex_alu_control  out  ALU_WIDTH_CODE  to execution stage
- ex_shift_control  out  SHIFT_WIDTH_CODE  to execution stage
- ex_in_a, ex_in_b  out  DATA_WIDTH  to execution stage
- ex_out  in  DATA_WIDTH  combinational result from execution stage
- rsp_valid  out  1  response buffer holds a result
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  ID_WIDTH  requester index of the result
- rsp_data  out  DATA_WIDTH  registered ex_out

## Operation
- can_issue = !rsp_valid || rsp_ready.
- Grant selection:
  - Search starts at the priority pointer `prio`.
  - The first index i, counting upward modulo NUM_REQ, with req_valid[i]=1 wins.
  - The grant is computed only when can_issue=1. Otherwise there is no grant.
- On a grant to i:
  - req_ready[i]=1 in that cycle.
  - ex_* outputs carry req_op[i].
  - At the clock edge: rsp_data←ex_out, rsp_id←i, rsp_valid←1, prio←(i+1) mod NUM_REQ.
- No grant:
  - ex_* outputs are all zero.
  - prio is unchanged.
  - If rsp_ready=1, rsp_valid←0.
- The response buffer is drained when rsp_valid && rsp_ready. A drain and a new grant in the same cycle refill the buffer: rsp_valid stays 1 with the new data.
- Held response: while rsp_valid && !rsp_ready, rsp_data and rsp_id are stable and all req_ready=0.
- Operation encoding is passed through unchanged. Both alu_op and shift_op set yields the ALU result; neither set yields 0. The block still returns a response for such an op and does not flag it.
- Requesters hold req_valid and req_op stable until req_ready. The block does not latch the request before acceptance.
- A requester deasserting valid before ready is legal: the request is dropped without response.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_data=0
  - prio=0
  - req_ready=0, ex_* =0
- Reset mid-operation discards any buffered response. A response held in the buffer is lost and never presented.

## Timing
- Request accepted at edge N (req_valid&&req_ready in cycle N-1/N): rsp_valid=1 with data from cycle N+1. Latency is 1 cycle.
- With rsp_ready held high: one accept per cycle, full throughput, no bubbles.
- req_ready depends combinationally on req_valid, prio, rsp_valid and rsp_ready. There are no combinational paths from ex_out to any output except through the register.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.

## Structure
- Add to core_pkg:
  - typedef struct packed ex_req_t {alu_op, shift_op, alu_control, shift_control, a, b}, sized from DATA_WIDTH, ALU_WIDTH_CODE and SHIFT_WIDTH_CODE.
  - Import alu_control_pkg/shift_control_pkg for the code widths.
- Sub-module core_rr_arbiter(NUM_REQ): inputs req, prio and enable; outputs a one-hot grant and its encoded index. It is reusable for later shared resources.
- The top level instantiates core_rr_arbiter, the response register and the operand mux. core_execution_stage is instantiated by the parent, not inside this block.

## Test plan
- Reset: assert rst for 2 cycles with all requesters valid -> rsp_valid=0 and req_ready=0 during reset. The first grant after release goes to req 0.
- Single request:
  - Stimulus: req 1 only, ALU add, a=5, b=7, rsp_ready=1.
  - Response: req_ready[1] for one cycle; next cycle rsp_valid=1, rsp_id=1, rsp_data=12.
- Round robin:
  - Stimulus: both requesters valid continuously for 6 ops, rsp_ready=1.
  - Response: rsp_id sequence 0,1,0,1,0,1, one result per cycle.
- Backpressure:
  - Stimulus: rsp_ready=0 for 3 cycles after the first result (shift-left a=1, b=4).
  - Response: rsp_data=16 held stable and req_ready=0 throughout. Releasing rsp_ready gives a drain and refill in the same cycle, and rsp_valid never drops.
- Encoding edge: alu_op=shift_op=0 -> rsp_data=0 with the correct rsp_id. alu_op=shift_op=1 -> ALU result.
- Reset mid-stream: rst while rsp_valid=1 and rsp_ready=0 -> the next cycle shows rsp_valid=0, prio=0, and the buffered result is never presented.

Source files
------------

// File: rtl/core_ex_arbiter_pkg.sv
// Shared types for the execution-stage arbiter: operation record, code widths
// and the modular pointer helper used by the round-robin search.
package core_ex_arbiter_pkg;
    localparam int DATA_WIDTH       = 32;
    localparam int ALU_WIDTH_CODE   = 3;
    localparam int SHIFT_WIDTH_CODE = 2;

    typedef enum logic [ALU_WIDTH_CODE-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_ctrl_e;

    typedef enum logic [SHIFT_WIDTH_CODE-1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_ctrl_e;

    typedef struct packed {
        logic                        alu_op;
        logic                        shift_op;
        logic [ALU_WIDTH_CODE-1:0]   alu_control;
        logic [SHIFT_WIDTH_CODE-1:0] shift_control;
        logic [DATA_WIDTH-1:0]       a;
        logic [DATA_WIDTH-1:0]       b;
    } ex_req_t;

    function automatic int unsigned rr_wrap(input int unsigned base, input int unsigned off,
                                            input int unsigned n);
        return (base + off) % n;
    endfunction
endpackage

// File: rtl/core_ex_arbiter_if.sv
// Request/response bundle between the requesters plus result consumer (master)
// and the arbiter (slave).
interface core_ex_arbiter_if #(
    parameter int NUM_REQ  = 2,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
);
    import core_ex_arbiter_pkg::*;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    ex_req_t [NUM_REQ-1:0] req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_WIDTH-1:0]   rsp_id;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/core_ex_arbiter_rr.sv
// Rotating-priority arbiter: the first requester at or after prio_i (mod NUM_REQ)
// wins; nothing is granted while enable_i is low.
module core_rr_arbiter
    import core_ex_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   prio_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_valid_o
);
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = '0;
        // Walk from the farthest offset to the nearest so the nearest valid one sticks.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'(rr_wrap(32'(prio_i), 32'(k), NUM_REQ));
            if (enable_i && req_i[idx]) begin
                grant_o       = '0;
                grant_o[idx]  = 1'b1;
                grant_idx_o   = idx;
                grant_valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/core_ex_arbiter.sv
// Shares one execution stage between NUM_REQ requesters with round-robin priority
// and a single-entry registered response buffer tagged with the winner's index.
module core_ex_arbiter
    import core_ex_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    core_ex_arbiter_if.slave            io,
    output logic                        ex_alu_op_o,
    output logic                        ex_shift_op_o,
    output logic [ALU_WIDTH_CODE-1:0]   ex_alu_control_o,
    output logic [SHIFT_WIDTH_CODE-1:0] ex_shift_control_o,
    output logic [DATA_WIDTH-1:0]       ex_in_a_o,
    output logic [DATA_WIDTH-1:0]       ex_in_b_o,
    input  logic [DATA_WIDTH-1:0]       ex_out_i
);
    logic                  can_issue;
    logic                  grant_vld;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_idx;
    ex_req_t               sel_op;

    logic [ID_WIDTH-1:0]   prio_q, prio_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    // A grant needs the buffer to be free or draining this very cycle.
    assign can_issue = !rsp_valid_q || io.rsp_ready;

    core_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_WIDTH)
    ) u_rr (
        .req_i         (io.req_valid),
        .prio_i        (prio_q),
        .enable_i      (can_issue && !rst),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_vld)
    );

    assign io.req_ready = grant;
    assign sel_op       = grant_vld ? io.req_op[grant_idx] : '0;

    assign ex_alu_op_o        = sel_op.alu_op;
    assign ex_shift_op_o      = sel_op.shift_op;
    assign ex_alu_control_o   = sel_op.alu_control;
    assign ex_shift_control_o = sel_op.shift_control;
    assign ex_in_a_o          = sel_op.a;
    assign ex_in_b_o          = sel_op.b;

    always_comb begin
        prio_d      = prio_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (grant_vld) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_data_d  = ex_out_i;
            prio_d      = ID_WIDTH'(rr_wrap(32'(grant_idx), 32'd1, NUM_REQ));
        end else if (io.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            prio_q      <= prio_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign io.rsp_valid = rsp_valid_q;
    assign io.rsp_id    = rsp_id_q;
    assign io.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_core_ex_arbiter.sv
// Bench for core_ex_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the round-robin/response-buffer rules.
module tb_core_ex_arbiter;
    import core_ex_arbiter_pkg::*;

    localparam int NUM_REQ  = 3;
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_ex_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) io ();

    logic                        ex_alu_op, ex_shift_op;
    logic [ALU_WIDTH_CODE-1:0]   ex_alu_control;
    logic [SHIFT_WIDTH_CODE-1:0] ex_shift_control;
    logic [DATA_WIDTH-1:0]       ex_in_a, ex_in_b, ex_out;
    ex_req_t                     ex_bus;

    core_ex_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .io                 (io),
        .ex_alu_op_o        (ex_alu_op),
        .ex_shift_op_o      (ex_shift_op),
        .ex_alu_control_o   (ex_alu_control),
        .ex_shift_control_o (ex_shift_control),
        .ex_in_a_o          (ex_in_a),
        .ex_in_b_o          (ex_in_b),
        .ex_out_i           (ex_out)
    );

    // Stand-in for the execution stage that the parent would attach.
    function automatic logic [DATA_WIDTH-1:0] ex_ref(input ex_req_t op);
        logic [4:0] sh;
        sh = op.b[4:0];
        if (op.alu_op) begin
            case (op.alu_control)
                ALU_ADD: return op.a + op.b;
                ALU_SUB: return op.a - op.b;
                ALU_AND: return op.a & op.b;
                ALU_OR:  return op.a | op.b;
                ALU_XOR: return op.a ^ op.b;
                default: return '0;
            endcase
        end else if (op.shift_op) begin
            case (op.shift_control)
                SH_SLL:  return op.a << sh;
                SH_SRL:  return op.a >> sh;
                SH_SRA:  return $signed(op.a) >>> sh;
                default: return '0;
            endcase
        end
        return '0;
    endfunction

    assign ex_bus = {ex_alu_op, ex_shift_op, ex_alu_control, ex_shift_control, ex_in_a, ex_in_b};
    assign ex_out = ex_ref(ex_bus);

    int n_pass, n_chk;
    int m_prio, last_win;
    logic                  m_valid;
    logic [ID_WIDTH-1:0]   m_id;
    logic [DATA_WIDTH-1:0] m_data;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic ex_req_t mk_op(input logic alu, input logic shf, input logic [2:0] ac,
                                      input logic [1:0] sc, input logic [31:0] a,
                                      input logic [31:0] b);
        return {alu, shf, ac, sc, a, b};
    endfunction

    function automatic ex_req_t rand_op();
        return mk_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), $urandom, $urandom);
    endfunction

    // One clock: check the combinational grant side, advance the model, check the buffer.
    task automatic cycle();
        int win;
        logic [ID_WIDTH-1:0] ix, wix;
        logic [NUM_REQ-1:0]  exp_rdy;
        ex_req_t             exp_op;
        #1;
        win = -1;
        wix = '0;
        if (!rst && (!m_valid || io.rsp_ready)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                ix = ID_WIDTH'((m_prio + k) % NUM_REQ);
                if (win < 0 && io.req_valid[ix]) begin
                    win = (m_prio + k) % NUM_REQ;
                    wix = ix;
                end
            end
        end
        exp_rdy = '0;
        exp_op  = '0;
        if (win >= 0) begin
            exp_rdy[wix] = 1'b1;
            exp_op       = io.req_op[wix];
        end
        chk("req_ready", 128'(io.req_ready), 128'(exp_rdy));
        chk("ex_bus", 128'(ex_bus), 128'(exp_op));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_id    = '0;
            m_data  = '0;
            m_prio  = 0;
        end else if (win >= 0) begin
            m_valid = 1'b1;
            m_id    = wix;
            m_data  = ex_ref(exp_op);
            m_prio  = (win + 1) % NUM_REQ;
        end else if (io.rsp_ready) begin
            m_valid = 1'b0;
        end
        last_win = win;
        #1;
        chk("rsp_valid", 128'(io.rsp_valid), 128'(m_valid));
        chk("rsp_id", 128'(io.rsp_id), 128'(m_id));
        chk("rsp_data", 128'(io.rsp_data), 128'(m_data));
        @(negedge clk);
    endtask

    task automatic drive_random();
        logic [ID_WIDTH-1:0] ix;
        for (int i = 0; i < NUM_REQ; i++) begin
            ix = ID_WIDTH'(i);
            if (!io.req_valid[ix] || last_win == i) begin
                io.req_valid[ix] = ($urandom_range(0, 99) < 60);
                io.req_op[ix]    = rand_op();
            end else if ($urandom_range(0, 99) < 5) begin
                io.req_valid[ix] = 1'b0;
            end
        end
        io.rsp_ready = ($urandom_range(0, 99) < 70);
    endtask

    initial begin
        n_pass = 0; n_chk = 0;
        m_valid = 1'b0; m_id = '0; m_data = '0; m_prio = 0; last_win = -1;

        // Reset with everyone requesting.
        rst = 1'b1;
        io.rsp_ready = 1'b0;
        io.req_valid = 3'b111;
        io.req_op[0] = mk_op(1'b1, 1'b0, ALU_ADD, SH_SLL, 32'd1, 32'd2);
        io.req_op[1] = mk_op(1'b1, 1'b0, ALU_SUB, SH_SLL, 32'd9, 32'd3);
        io.req_op[2] = mk_op(1'b0, 1'b1, ALU_ADD, SH_SRL, 32'd64, 32'd2);
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        chk("first_grant", 128'(last_win), 128'(0));
        io.req_valid = 3'b000;
        io.rsp_ready = 1'b1;
        cycle();

        // Single request from requester 1.
        io.req_valid = 3'b010;
        io.req_op[1] = mk_op(1'b1, 1'b0, ALU_ADD, SH_SLL, 32'd5, 32'd7);
        cycle();
        chk("single_win", 128'(last_win), 128'(1));
        chk("single_valid", 128'(io.rsp_valid), 128'(1));
        chk("single_id", 128'(io.rsp_id), 128'(1));
        chk("single_data", 128'(io.rsp_data), 128'(12));
        io.req_valid = 3'b000;
        cycle();

        // Two requesters continuously valid alternate every cycle.
        io.req_valid = 3'b011;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_seq", 128'(last_win), 128'(k % 2));
            chk("rr_valid", 128'(io.rsp_valid), 128'(1));
            if (last_win == 0) io.req_op[0] = rand_op();
            if (last_win == 1) io.req_op[1] = rand_op();
        end
        io.req_valid = 3'b000;
        cycle();

        // Backpressure on a shift result, then drain+refill in one edge.
        io.req_valid = 3'b001;
        io.req_op[0] = mk_op(1'b0, 1'b1, ALU_ADD, SH_SLL, 32'd1, 32'd4);
        cycle();
        io.rsp_ready = 1'b0;
        io.req_valid = 3'b011;
        io.req_op[0] = mk_op(1'b1, 1'b0, ALU_SUB, SH_SLL, 32'd9, 32'd4);
        io.req_op[1] = mk_op(1'b1, 1'b0, ALU_ADD, SH_SLL, 32'd2, 32'd3);
        repeat (3) begin
            cycle();
            chk("bp_data", 128'(io.rsp_data), 128'(16));
            chk("bp_ready", 128'(io.req_ready), 128'(0));
            chk("bp_valid", 128'(io.rsp_valid), 128'(1));
        end
        io.rsp_ready = 1'b1;
        cycle();
        chk("refill_valid", 128'(io.rsp_valid), 128'(1));
        chk("refill_id", 128'(io.rsp_id), 128'(1));
        chk("refill_data", 128'(io.rsp_data), 128'(5));
        io.req_valid = 3'b000;
        cycle();

        // Encoding edges: no op selected, and both selected.
        io.req_valid = 3'b100;
        io.req_op[2] = mk_op(1'b0, 1'b0, ALU_ADD, SH_SLL, 32'd3, 32'd4);
        cycle();
        chk("enc_none_data", 128'(io.rsp_data), 128'(0));
        chk("enc_none_id", 128'(io.rsp_id), 128'(2));
        io.req_valid = 3'b001;
        io.req_op[0] = mk_op(1'b1, 1'b1, ALU_ADD, SH_SLL, 32'd3, 32'd4);
        cycle();
        chk("enc_both_data", 128'(io.rsp_data), 128'(7));
        chk("enc_both_id", 128'(io.rsp_id), 128'(0));
        io.req_valid = 3'b000;
        cycle();

        // Reset while a response is held.
        io.req_valid = 3'b010;
        io.req_op[1] = mk_op(1'b1, 1'b0, ALU_ADD, SH_SLL, 32'd1, 32'd1);
        io.rsp_ready = 1'b0;
        cycle();
        chk("mid_held", 128'(io.rsp_valid), 128'(1));
        io.req_valid = 3'b000;
        rst = 1'b1;
        cycle();
        chk("mid_rst_valid", 128'(io.rsp_valid), 128'(0));
        rst = 1'b0;
        io.rsp_ready = 1'b1;
        cycle();
        chk("mid_lost", 128'(io.rsp_valid), 128'(0));
        io.req_valid = 3'b111;
        for (int i = 0; i < NUM_REQ; i++) io.req_op[i] = rand_op();
        cycle();
        chk("mid_prio0", 128'(last_win), 128'(0));

        // Randomized traffic with drops and backpressure.
        repeat (600) begin
            drive_random();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
